// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-key debounce, plus an independent
// debouncer for a raw submit pushbutton. All activity advances on a divided tick.
module keypad_scanner #(
  parameter int tickDiv  = 25000,
  parameter int debTicks = 20
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [3:0] col,
  input  logic       btnSubmit,
  output logic [3:0] num,
  output logic       numPressed,
  output logic [2:0] opt,
  output logic       optPressed,
  output logic       submit
);

  localparam int DivW = (tickDiv > 1) ? $clog2(tickDiv) : 1;
  localparam int CntW = $clog2(debTicks + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(tickDiv - 1);
  localparam logic [CntW-1:0] CntTop  = CntW'(debTicks);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   sub_cnt_q, sub_cnt_d;
  logic [3:0]        row_q, row_d;
  logic [3:0]        code_q, code_d;
  logic [3:0]        num_q, num_d;
  logic [2:0]        opt_q, opt_d;
  logic              num_pressed_q, num_pressed_d;
  logic              opt_pressed_q, opt_pressed_d;
  logic              submit_q, submit_d;
  logic              sync1_q, sync2_q;

  logic              tick;
  logic              col_idle;
  logic [1:0]        row_idx;
  logic [1:0]        col_idx;
  logic [3:0]        cur_code;
  logic [3:0]        row_next;
  logic [CntW-1:0]   cnt_inc;
  logic [CntW-1:0]   sub_cnt_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SCAN;
      div_q         <= '0;
      cnt_q         <= '0;
      sub_cnt_q     <= '0;
      row_q         <= 4'b1110;
      code_q        <= '0;
      num_q         <= '0;
      opt_q         <= '0;
      num_pressed_q <= 1'b0;
      opt_pressed_q <= 1'b0;
      submit_q      <= 1'b0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      cnt_q         <= cnt_d;
      sub_cnt_q     <= sub_cnt_d;
      row_q         <= row_d;
      code_q        <= code_d;
      num_q         <= num_d;
      opt_q         <= opt_d;
      num_pressed_q <= num_pressed_d;
      opt_pressed_q <= opt_pressed_d;
      submit_q      <= submit_d;
      sync1_q       <= btnSubmit;
      sync2_q       <= sync1_q;
    end
  end

  // Scan decode: the lowest-index low column wins when several are pressed.
  always_comb begin
    tick     = (div_q == DivLast);
    div_d    = tick ? '0 : div_q + 1'b1;
    col_idle = (col == 4'hF);
    row_next = {row_q[2:0], row_q[3]};
    unique case (row_q)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    if (!col[0])      col_idx = 2'd0;
    else if (!col[1]) col_idx = 2'd1;
    else if (!col[2]) col_idx = 2'd2;
    else              col_idx = 2'd3;
    cur_code    = {row_idx, col_idx};
    cnt_inc     = (cnt_q == CntTop) ? cnt_q : cnt_q + 1'b1;
    sub_cnt_inc = (sub_cnt_q == CntTop) ? sub_cnt_q : sub_cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        SCAN:      if (!col_idle) state_d = DEB_PRESS;
        DEB_PRESS: begin
          if (col_idle || cur_code != code_q) state_d = SCAN;
          else if (cnt_inc == CntTop)         state_d = HELD;
        end
        HELD:      if (col_idle) state_d = DEB_REL;
        DEB_REL: begin
          if (!col_idle)              state_d = HELD;
          else if (cnt_inc == CntTop) state_d = SCAN;
        end
        default:   state_d = SCAN;
      endcase
    end
  end

  // Row, code, counters and key outputs all move with the state transitions.
  always_comb begin
    row_d         = row_q;
    code_d        = code_q;
    cnt_d         = cnt_q;
    num_d         = num_q;
    opt_d         = opt_q;
    num_pressed_d = num_pressed_q;
    opt_pressed_d = opt_pressed_q;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (col_idle) begin
            row_d = row_next;
          end else begin
            code_d = cur_code;
            cnt_d  = '0;
          end
        end
        DEB_PRESS: begin
          if (!col_idle && cur_code == code_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntTop) begin
              if (code_q < 4'd10) begin
                num_d         = code_q;
                num_pressed_d = 1'b1;
              end else begin
                opt_d         = 3'(code_q - 4'd10);
                opt_pressed_d = 1'b1;
              end
            end
          end
        end
        HELD: begin
          if (col_idle) cnt_d = '0;
        end
        DEB_REL: begin
          if (col_idle) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntTop) begin
              num_pressed_d = 1'b0;
              opt_pressed_d = 1'b0;
              row_d         = row_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Submit flips only after debTicks consecutive disagreeing ticks.
  always_comb begin
    submit_d  = submit_q;
    sub_cnt_d = sub_cnt_q;
    if (tick) begin
      if (sync2_q != submit_q) begin
        if (sub_cnt_inc == CntTop) begin
          submit_d  = ~submit_q;
          sub_cnt_d = '0;
        end else begin
          sub_cnt_d = sub_cnt_inc;
        end
      end else begin
        sub_cnt_d = '0;
      end
    end
  end

  assign row        = row_q;
  assign num        = num_q;
  assign opt        = opt_q;
  assign numPressed = num_pressed_q;
  assign optPressed = opt_pressed_q;
  assign submit     = submit_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Drives keypad_scanner from a simulated 4x4 key matrix and compares every tick
// against a key-level behavioural model of the scanner and submit debouncer.
module tb_keypad_scanner;

  localparam int TickDiv  = 4;
  localparam int DebTicks = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        btnSubmit = 1'b0;
  logic [3:0]  num;
  logic        numPressed;
  logic [2:0]  opt;
  logic        optPressed;
  logic        submit;

  logic [15:0] keys = '0;
  logic        bounce_open = 1'b0;

  int total = 0;
  int passed = 0;

  // Model state, expressed per key rather than per FSM state.
  int m_ri, m_cand, m_streak, m_rel_streak, m_sub_streak;
  bit m_held, m_releasing;
  int m_num, m_opt;
  bit m_np, m_op, m_sub;

  keypad_scanner #(.tickDiv(TickDiv), .debTicks(DebTicks)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .btnSubmit(btnSubmit),
    .num(num), .numPressed(numPressed), .opt(opt), .optPressed(optPressed),
    .submit(submit)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] col_from_keys(input logic [3:0] r, input logic [15:0] k);
    logic [3:0] c;
    c = 4'hF;
    for (int i = 0; i < 4; i++)
      if (!r[i])
        for (int j = 0; j < 4; j++)
          if (k[i*4+j]) c[j] = 1'b0;
    return c;
  endfunction

  assign col = bounce_open ? 4'hF : col_from_keys(row, keys);

  function automatic logic [3:0] model_row();
    logic [3:0] r;
    r = 4'hF;
    r[m_ri] = 1'b0;
    return r;
  endfunction

  task automatic reset_model();
    m_ri = 0; m_cand = -1; m_streak = 0; m_rel_streak = 0; m_sub_streak = 0;
    m_held = 0; m_releasing = 0;
    m_num = 0; m_opt = 0; m_np = 0; m_op = 0; m_sub = 0;
  endtask

  task automatic model_tick();
    logic [3:0] c;
    int code;
    c = bounce_open ? 4'hF : col_from_keys(model_row(), keys);
    code = -1;
    for (int j = 3; j >= 0; j--) if (!c[j]) code = m_ri * 4 + j;
    if (m_held) begin
      if (!m_releasing) begin
        if (code < 0) begin m_releasing = 1; m_rel_streak = 0; end
      end else if (code < 0) begin
        m_rel_streak++;
        if (m_rel_streak == DebTicks) begin
          m_held = 0; m_np = 0; m_op = 0; m_cand = -1;
          m_ri = (m_ri + 1) % 4;
        end
      end else begin
        m_releasing = 0;
      end
    end else if (m_cand < 0) begin
      if (code < 0) m_ri = (m_ri + 1) % 4;
      else begin m_cand = code; m_streak = 0; end
    end else if (code == m_cand) begin
      m_streak++;
      if (m_streak == DebTicks) begin
        m_held = 1; m_releasing = 0;
        if (m_cand < 10) begin m_np = 1; m_num = m_cand; end
        else begin m_op = 1; m_opt = m_cand - 10; end
      end
    end else begin
      m_cand = -1;
    end
    if (btnSubmit !== m_sub) begin
      m_sub_streak++;
      if (m_sub_streak == DebTicks) begin m_sub = ~m_sub; m_sub_streak = 0; end
    end else begin
      m_sub_streak = 0;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_output(input string tag);
    check({tag, ".row"}, {4'h0, row}, {4'h0, model_row()});
    check({tag, ".numPressed"}, {7'h0, numPressed}, {7'h0, m_np});
    check({tag, ".optPressed"}, {7'h0, optPressed}, {7'h0, m_op});
    check({tag, ".num"}, {4'h0, num}, 8'(m_num));
    check({tag, ".opt"}, {5'h0, opt}, 8'(m_opt));
    check({tag, ".submit"}, {7'h0, submit}, {7'h0, m_sub});
    check({tag, ".exclusive"}, {7'h0, numPressed & optPressed}, 8'h0);
  endtask

  // One tick: TickDiv clock edges, the last of which is the DUT tick edge.
  task automatic apply_stimulus(input int n, input string tag);
    for (int t = 0; t < n; t++) begin
      repeat (TickDiv) @(posedge clk);
      model_tick();
      #1;
      check_output(tag);
    end
  endtask

  initial begin
    reset_model();
    #12;
    check_output("reset");
    @(posedge clk);
    #1 reset = 1'b1;

    apply_stimulus(20, "idle");

    keys[9] = 1'b1;
    apply_stimulus(12, "press9");
    check("press9.flag", {7'h0, numPressed}, 8'h1);
    check("press9.num", {4'h0, num}, 8'h9);
    keys = '0;
    apply_stimulus(6, "release9");
    check("release9.flag", {7'h0, numPressed}, 8'h0);
    check("release9.num", {4'h0, num}, 8'h9);

    keys[12] = 1'b1;
    apply_stimulus(12, "press12");
    check("press12.flag", {7'h0, optPressed}, 8'h1);
    check("press12.opt", {5'h0, opt}, 8'h2);
    keys = '0;
    apply_stimulus(6, "release12");

    keys[9] = 1'b1;
    for (int t = 0; t < 12; t++) begin
      bounce_open = ~bounce_open;
      apply_stimulus(1, "bouncePress");
    end
    check("bouncePress.flag", {7'h0, numPressed}, 8'h0);
    bounce_open = 1'b0;
    apply_stimulus(12, "steady9");
    for (int t = 0; t < 10; t++) begin
      keys[9] = ~keys[9];
      apply_stimulus(1, "bounceRel");
    end
    check("bounceRel.flag", {7'h0, numPressed}, 8'h1);
    keys = '0;
    apply_stimulus(6, "release9b");

    keys[5] = 1'b1;
    keys[7] = 1'b1;
    apply_stimulus(12, "multiCol");
    check("multiCol.num", {4'h0, num}, 8'h5);
    keys = '0;
    apply_stimulus(6, "releaseMulti");

    btnSubmit = 1'b1;
    apply_stimulus(2, "subShort");
    btnSubmit = 1'b0;
    apply_stimulus(4, "subShortRel");
    check("subShort.submit", {7'h0, submit}, 8'h0);
    btnSubmit = 1'b1;
    keys[3] = 1'b1;
    apply_stimulus(4, "subLong");
    check("subLong.submit", {7'h0, submit}, 8'h1);
    apply_stimulus(10, "subWithKey");
    check("subWithKey.num", {4'h0, num}, 8'h3);
    btnSubmit = 1'b0;
    keys = '0;
    apply_stimulus(8, "subRelease");

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(2))
          0:       keys = '0;
          1:       keys = 16'(1 << $urandom_range(15));
          default: keys = 16'((1 << $urandom_range(15)) | (1 << $urandom_range(15)));
        endcase
      end
      if ($urandom_range(4) == 0) btnSubmit = ~btnSubmit;
      bounce_open = ($urandom_range(9) == 0);
      apply_stimulus(1, "random");
    end

    bounce_open = 1'b0;
    btnSubmit = 1'b0;
    keys = '0;
    apply_stimulus(8, "settle");
    keys[2] = 1'b1;
    apply_stimulus(12, "preReset");
    check("preReset.flag", {7'h0, numPressed}, 8'h1);
    reset = 1'b0;
    #1;
    check("asyncReset.flag", {7'h0, numPressed}, 8'h0);
    check("asyncReset.row", {4'h0, row}, 8'hE);
    check("asyncReset.num", {4'h0, num}, 8'h0);
    reset_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    apply_stimulus(12, "resume");
    check("resume.num", {4'h0, num}, 8'h2);
    keys = '0;
    apply_stimulus(6, "resumeRel");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter tickDiv, default 25000, the number of clk cycles per scan tick (1 ms at 25 MHz).
REQ-002 SHALL have parameter debTicks, default 20, the number of consecutive stable ticks needed to accept a press or release.
REQ-003 SHALL have port clk, input, 1 bit: the system clock, and the only clock in the block.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port row, output, 4 bits: keypad row drive, active-low, one-hot.
REQ-006 SHALL have port col, input, 4 bits: keypad column sense, active-low, externally pulled up and externally synchronised.
REQ-007 SHALL have port btnSubmit, input, 1 bit: submit pushbutton, active-high, raw (undebounced).
REQ-008 SHALL have port num, output, 4 bits: digit 0-9 of the held key.
REQ-009 SHALL have port numPressed, output, 1 bit: high while a debounced digit key is held.
REQ-010 SHALL have port opt, output, 3 bits: operation code 0-5 of the held key.
REQ-011 SHALL have port optPressed, output, 1 bit: high while a debounced operation key is held.
REQ-012 SHALL have port submit, output, 1 bit: debounced level of btnSubmit.

Function
REQ-013 SHALL generate a one-cycle tick every tickDiv clk cycles from a free-running counter; all scan and debounce activity SHALL advance only on tick.
REQ-014 SHALL implement key FSM states SCAN, DEB_PRESS, HELD, DEB_REL.
REQ-015 In SCAN, on each tick: if col==4'hF, rotate row (1110->1101->1011->0111->1110); otherwise latch the code, freeze row, clear the debounce count and enter DEB_PRESS.
REQ-016 Code = row index*4 + lowest-index low col bit. Multiple low columns SHALL resolve to the lowest column.
REQ-017 In DEB_PRESS, on each tick: a code equal to the latched code increments the count; col==4'hF or a different code returns to SCAN with row unchanged.
REQ-018 When the count reaches debTicks, SHALL enter HELD and, on the same clk edge, assert the output for the key:
- codes 0-9: numPressed=1, num=code;
- codes 10-15: optPressed=1, opt=code-10.
REQ-019 numPressed and optPressed SHALL never be high together; num and opt SHALL stay stable while their pressed flag is high.
REQ-020 In HELD, on a tick with col==4'hF, SHALL enter DEB_REL with the count cleared; any other column change while held SHALL be ignored.
REQ-021 In DEB_REL, each tick with col==4'hF increments the count; any tick with col!=4'hF returns to HELD.
REQ-022 When the DEB_REL count reaches debTicks, SHALL deassert both pressed flags, resume rotation from the next row and return to SCAN.
REQ-023 num and opt SHALL hold their last value after release.
REQ-024 Submit path SHALL be an independent debouncer: submit changes only after btnSubmit differs from submit on debTicks consecutive ticks; any agreeing tick clears the count.
REQ-025 Submit SHALL operate concurrently with the key FSM, with no interaction between the two.
REQ-026 All outputs SHALL be registered.
REQ-027 Debounce counters SHALL saturate and SHALL not wrap.

Reset
REQ-028 While reset=0, SHALL force: row=4'b1110, num=0, opt=0, numPressed=0, optPressed=0, submit=0, state=SCAN, all counters=0.
REQ-029 Reset asserted mid-press SHALL drop all pressed flags immediately, asynchronously.
REQ-030 After reset release, operation SHALL resume normally with the first tick occurring tickDiv cycles later.

Verification (tickDiv=4, debTicks=3)
REQ-031 Idle col=F for 20 ticks -> row cycles 1110,1101,1011,0111,1110...; all pressed flags stay 0.
REQ-032 Hold col=1101 while row=1011 (code 9) for 5 ticks -> numPressed=1, num=9 after the 3rd matching tick; release for 3 ticks -> numPressed=0, num stays 9.
REQ-033 Hold col=1110 while row=0111 (code 12) -> optPressed=1, opt=2; numPressed stays 0 throughout.
REQ-034 Bounce col 1101/F/1101 on alternating ticks -> no flag asserted, scan resumes; bounce during DEB_REL -> flag stays 1.
REQ-035 Press btnSubmit for 2 ticks then release -> submit stays 0; press for 4 ticks -> submit=1 after the 3rd tick, while a simultaneous digit press is still reported correctly.
REQ-036 Pull reset low while numPressed=1 -> numPressed=0 and row=1110 with no clk edge needed.
